// File: rtl/popcount_sched_pkg.sv
// Shared types and width helpers for the popcount scheduler.
package popcount_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    function automatic int id_width(input int num_req);
        return $clog2(num_req);
    endfunction

endpackage

// File: rtl/popcount_sched_bitcnt_chunk.sv
// Combinational population count of one CHUNK_WIDTH slice.
module bitcnt_chunk #(
    parameter int CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0]     i_chunk,
    output logic [$clog2(CHUNK_WIDTH):0] o_count
);

    localparam int CNT_W = $clog2(CHUNK_WIDTH) + 1;

    always_comb begin
        o_count = '0;
        for (int b = 0; b < CHUNK_WIDTH; b++) begin
            o_count = o_count + CNT_W'(i_chunk[b]);
        end
    end

endmodule

// File: rtl/popcount_sched.sv
// Arbitrated multi-requester popcount engine, CHUNK_WIDTH bits per cycle.
// Define POPCOUNT_SCHED_RR_EN for a round-robin arbiter; default is fixed priority.
module popcount_sched
    import popcount_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 4,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [cnt_width(DATA_WIDTH)-1:0]  res_count,
    output logic [id_width(NUM_REQ)-1:0]      res_id,
    output logic                              busy
);

    localparam int CNT_W  = cnt_width(DATA_WIDTH);
    localparam int ID_W   = id_width(NUM_REQ);
    localparam int NBEATS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int BEAT_W = $clog2(NBEATS) + 1;
    localparam int CHK_W  = $clog2(CHUNK_WIDTH) + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_acc;
    logic [CNT_W-1:0]      w_acc_nxt;
    logic [BEAT_W-1:0]     r_beat;
    logic [CNT_W-1:0]      r_res_count;
    logic [ID_W-1:0]       r_res_id;
    logic [CHK_W-1:0]      w_chunk_cnt;
    logic                  w_last_beat;
    logic                  w_gnt_found;
    logic [ID_W-1:0]       w_gnt_idx;
    int                    w_base;
    int                    w_cand;
`ifdef POPCOUNT_SCHED_RR_EN
    logic [ID_W-1:0]       r_ptr;
`endif

    bitcnt_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_bitcnt (
        .i_chunk (r_shift[CHUNK_WIDTH-1:0]),
        .o_count (w_chunk_cnt)
    );

    assign w_acc_nxt   = r_acc + CNT_W'(w_chunk_cnt);
    assign w_last_beat = (r_beat == BEAT_W'(NBEATS - 1));

    // Scan offsets high-to-low so the candidate closest to the base wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = 0;
        w_base      = 0;
`ifdef POPCOUNT_SCHED_RR_EN
        w_base      = int'(r_ptr);
`endif
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = w_base + k;
            if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
            if (req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = ID_W'(w_cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (resetn && r_state == IDLE && w_gnt_found) req_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_gnt_found) w_state_nxt = COUNT;
            COUNT:   if (w_last_beat) w_state_nxt = DONE;
            DONE:    if (res_ready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_acc       <= '0;
            r_beat      <= '0;
            r_res_count <= '0;
            r_res_id    <= '0;
`ifdef POPCOUNT_SCHED_RR_EN
            r_ptr       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_gnt_found) begin
                        r_shift  <= req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_acc    <= '0;
                        r_beat   <= '0;
                        r_res_id <= w_gnt_idx;
`ifdef POPCOUNT_SCHED_RR_EN
                        r_ptr    <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                      : w_gnt_idx + ID_W'(1);
`endif
                    end
                end
                COUNT: begin
                    r_acc   <= w_acc_nxt;
                    r_shift <= r_shift >> CHUNK_WIDTH;
                    r_beat  <= r_beat + BEAT_W'(1);
                    // Result register is separate so it survives the next accept.
                    if (w_last_beat) r_res_count <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign res_count = r_res_count;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_popcount_sched.sv
// Self-checking bench for popcount_sched; honours POPCOUNT_SCHED_RR_EN if defined.
module tb_popcount_sched;

    localparam int DW     = 16;
    localparam int NR     = 4;
    localparam int CW     = 4;
    localparam int NBEATS = DW / CW;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_count;
    logic [1:0]       res_id;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    popcount_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CHUNK_WIDTH(CW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_popcount(input logic [DW-1:0] w);
        return $countones(w);
    endfunction

    // One isolated request; hold = cycles of res_ready=0 in DONE.
    task automatic run_word(input int idx, input logic [DW-1:0] word, input int hold, input bit first);
        int waited;
        int lat;
        int exp_cnt;
        exp_cnt = ref_popcount(word);
        req_data[idx*DW +: DW] = word;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        res_ready = 1'b0;
        waited = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            check("grant_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        if (first) check("first_accept_wait", waited, 0);
        check("grant_onehot", req_ready, 1 << idx);
        @(posedge clk); #1;
        req_valid = '0;
        req_data[idx*DW +: DW] = ~word;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 30) begin
            check("busy_counting", busy, 1);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, NBEATS);
        check("res_count", res_count, exp_cnt);
        check("res_id", res_id, idx);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_valid", res_valid, 1);
            check("bp_count", res_count, exp_cnt);
            check("bp_id", res_id, idx);
            check("bp_ready", req_ready, 0);
            check("bp_busy", busy, 1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_valid", res_valid, 0);
        check("post_busy", busy, 0);
        check("post_count_held", res_count, exp_cnt);
    endtask

    task automatic contention();
        int cyc;
        int n_acc;
        int last_acc;
        int ptr;
        int exp_idx;
        int just_acc;
        int q_id[$];
        int q_cnt[$];
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
        req_valid = '1;
        res_ready = 1'b1;
        cyc = 0; n_acc = 0; last_acc = -1; ptr = 0; just_acc = -1;
        #1;
        while ((n_acc < 5 || q_id.size() > 0) && cyc < 200) begin
            if (n_acc == 5) req_valid = '0;
            if (req_ready != '0 && n_acc < 5) begin
`ifdef POPCOUNT_SCHED_RR_EN
                exp_idx = ptr;
                ptr = (ptr + 1) % NR;
`else
                exp_idx = 0;
`endif
                check("cont_grant", req_ready, 1 << exp_idx);
                if (last_acc >= 0) check("cont_spacing", cyc - last_acc, NBEATS + 2);
                last_acc = cyc;
                q_id.push_back(exp_idx);
                q_cnt.push_back(ref_popcount(req_data[exp_idx*DW +: DW]));
                just_acc = exp_idx;
                n_acc++;
            end
            if (res_valid === 1'b1) begin
                if (q_id.size() == 0) begin
                    check("cont_spurious_result", 1, 0);
                end else begin
                    check("cont_id", res_id, q_id.pop_front());
                    check("cont_count", res_count, q_cnt.pop_front());
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (just_acc >= 0) begin
                req_data[just_acc*DW +: DW] = DW'($urandom);
                just_acc = -1;
            end
        end
        check("cont_accepts", n_acc, 5);
        check("cont_drained", q_id.size(), 0);
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_count();
        int pulses;
        int waited;
        req_data[3*DW +: DW] = 16'hFFFF;
        req_valid = 4'b1000;
        waited = 0;
        #1;
        while (req_ready[3] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rst_grant", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        req_valid = '1;
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_count", res_count, 0);
        check("rst_id", res_id, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        req_valid = '0;
        @(posedge clk); #2;
        resetn = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1 || busy === 1'b1) pulses++;
        end
        check("rst_no_result", pulses, 0);
        run_word(1, 16'h0F0F, 0, 1'b0);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("reset_ready", req_ready, 0);
        check("reset_valid", res_valid, 0);
        check("reset_count", res_count, 0);
        check("reset_id", res_id, 0);
        check("reset_busy", busy, 0);
        req_valid = '0;
        @(posedge clk); #2;
        resetn = 1'b1;

        run_word(2, 16'hFFFF, 0, 1'b1);
        run_word(0, 16'h0000, 0, 1'b0);
        run_word(1, 16'h8001, 0, 1'b0);
        run_word(3, 16'hA5A5, 0, 1'b0);
        run_word(2, 16'h1234, 10, 1'b0);

        contention();
        reset_mid_count();

        for (int t = 0; t < 20; t++) begin
            run_word(int'($urandom_range(0, NR - 1)), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/popcount_sched.md
POPCOUNT_SCHED -- requirements
Module: popcount_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bit width of each request word.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter CHUNK_WIDTH, default 4: bits counted per cycle; must divide DATA_WIDTH exactly.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot or zero grant; accept occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_count  output  $clog2(DATA_WIDTH)+1  number of 1 bits in the accepted word.
REQ-012 res_id  output  $clog2(NUM_REQ)  index of the requester that owns res_count.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-015 In IDLE, req_ready SHALL assert for exactly one requester with req_valid high, chosen by the arbiter; in COUNT and DONE, req_ready SHALL be all zero.
REQ-016 On accept, the block SHALL:
- capture the granted word into a shift register;
- clear the accumulator and the beat counter;
- latch the grant index into res_id;
- enter COUNT.
REQ-017 Each COUNT cycle SHALL:
- add the popcount of the low CHUNK_WIDTH bits of the shift register to the accumulator;
- shift the register right by CHUNK_WIDTH;
- increment the beat counter.
REQ-018 After NBEATS = DATA_WIDTH/CHUNK_WIDTH COUNT cycles, the FSM SHALL enter DONE with res_valid=1 and res_count equal to the full popcount, so res_valid rises NBEATS cycles after the accept edge (4 at default parameters).
REQ-019 In DONE, res_valid, res_count and res_id SHALL hold stable until res_valid and res_ready are both high on an edge; the FSM then returns to IDLE and res_valid drops.
REQ-020 No new request SHALL be accepted on the edge that completes the result handshake, so the minimum spacing between accepts is NBEATS+2 cycles.
REQ-021 The accumulator SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL NOT overflow; an all-ones word yields exactly DATA_WIDTH.
REQ-022 A requester SHALL be allowed to drop req_valid before it is granted; no state changes for that requester.
REQ-023 res_count SHALL retain its last value outside DONE, and res_valid is the only qualifier for it.

Reset
REQ-024 When resetn is low, the block SHALL force:
- state to IDLE;
- res_valid, res_count, res_id, busy, accumulator, beat counter and shift register to 0;
- the round-robin pointer to 0;
- req_ready to all zero, including while resetn is held low.
REQ-025 Reset asserted mid-COUNT or mid-DONE SHALL discard the in-flight result, with no res_valid pulse after release.
REQ-026 The first accept after reset SHALL be possible on the first rising edge with resetn high.

Configuration
REQ-027 With macro POPCOUNT_SCHED_RR_EN defined, the arbiter SHALL be round-robin: search starts at the pointer, and on each accept the pointer becomes (granted index + 1) mod NUM_REQ.
REQ-028 Without POPCOUNT_SCHED_RR_EN, the arbiter SHALL be fixed priority with the lowest index winning, and no pointer register is built.

Structure
REQ-029 Package popcount_sched_pkg SHALL hold:
- the FSM state enum (IDLE, COUNT, DONE);
- width helper constants/functions for the count and id widths.
REQ-030 A combinational sub-module bitcnt_chunk SHALL count the 1 bits of one CHUNK_WIDTH slice, with one instance in popcount_sched.

Verification
REQ-031 Single word: req_valid[2]=1, word 16'hFFFF -> accept in IDLE; 4 cycles later res_valid=1, res_count=16, res_id=2.
REQ-032 Boundary words: 16'h0000 -> res_count=0; 16'h8001 -> res_count=2; 16'hA5A5 -> res_count=8.
REQ-033 Contention with RR_EN, all four req_valid held high -> grant order 0,1,2,3,0, with each accept exactly 6 cycles apart when res_ready=1.
REQ-034 Contention without RR_EN, all four req_valid held high -> requester 0 is granted every time.
REQ-035 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_count and res_id stay constant, req_ready stays 0, and busy stays 1.
REQ-036 Reset mid-COUNT: resetn pulsed low at beat 2 -> all outputs 0; no res_valid after release; the next request completes with the correct count.
